// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Instruction sequencer for the 8-bit core. Owns the program
//               counter, latches the instruction returned by program memory
//               and steps it through FETCH/DECODE/EXEC/WAIT. Jumps, branches
//               and halts are resolved here; all other opcodes go to the
//               datapath with a one-cycle exec_en strobe. Supports free-run
//               (run level) and single-step (step pulse) operation.
// Ports       : clk       - system clock, rising edge
//               res       - asynchronous active-high reset
//               run       - level, fetch continuously while high
//               step      - pulse, run one instruction (sampled in IDLE only)
//               ir_in     - instruction word addressed by pc
//               zero_flag - datapath zero flag, used by JZ in DECODE
//               dp_busy   - datapath busy, holds the sequencer in WAIT
//               pc        - program counter to program memory
//               ir        - latched current instruction
//               exec_en   - one-cycle datapath execute strobe
//               halted    - high while in HALT
//               fault     - sticky, jump target outside program memory
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16,
    parameter int CMD_CNT  = 64
) (
    input  logic                clk,
    input  logic                res,
    input  logic                run,
    input  logic                step,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic                zero_flag,
    input  logic                dp_busy,
    output logic [PC_WIDTH-1:0] pc,
    output logic [IR_WIDTH-1:0] ir,
    output logic                exec_en,
    output logic                halted,
    output logic                fault
);

    localparam logic [3:0]          c_OP_JMP  = 4'b0101;
    localparam logic [3:0]          c_OP_JZ   = 4'b0110;
    localparam logic [3:0]          c_OP_HLT  = 4'b1111;
    localparam logic [PC_WIDTH-1:0] c_PC_LAST = PC_WIDTH'(CMD_CNT - 1);
    localparam logic [PC_WIDTH-1:0] c_PC_ONE  = PC_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic                  exec_en_q, exec_en_d;
    logic                  halted_q, halted_d;
    logic                  fault_q, fault_d;

    logic [3:0]            w_opcode;
    logic [PC_WIDTH-1:0]   w_target;
    logic [PC_WIDTH-1:0]   w_next_pc;
    logic                  w_tgt_ok;
    state_t                w_resume;

    assign w_opcode = ir_q[15:12];

    // Jump target field is 8 bits; fit it to the program counter width.
    generate
        if (PC_WIDTH > 8) begin : g_tgt_zext
            assign w_target = {{(PC_WIDTH-8){1'b0}}, ir_q[7:0]};
        end else begin : g_tgt_trunc
            assign w_target = ir_q[PC_WIDTH-1:0];
        end
    endgenerate

    assign w_tgt_ok  = (32'(w_target) < 32'(CMD_CNT));
    assign w_next_pc = (pc_q == c_PC_LAST) ? '0 : (pc_q + c_PC_ONE);

    // After an instruction retires, keep going only while run is held;
    // a dropped run lets the current instruction finish and then parks.
    assign w_resume = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        exec_en_d = 1'b0;
        halted_d  = halted_q;
        fault_d   = fault_q;

        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = ir_in;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    c_OP_HLT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    c_OP_JMP, c_OP_JZ: begin
                        if ((w_opcode == c_OP_JMP) || zero_flag) begin
                            if (w_tgt_ok) begin
                                pc_d    = w_target;
                                state_d = w_resume;
                            end else begin
                                fault_d  = 1'b1;
                                halted_d = 1'b1;
                                state_d  = S_HALT;
                            end
                        end else begin
                            pc_d    = w_next_pc;
                            state_d = w_resume;
                        end
                    end
                    default: begin
                        // Strobe is registered, so it is high during EXEC.
                        exec_en_d = 1'b1;
                        state_d   = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dp_busy) begin
                    pc_d    = w_next_pc;
                    state_d = w_resume;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            exec_en_q <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            exec_en_q <= exec_en_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign exec_en = exec_en_q;
    assign halted  = halted_q;
    assign fault   = fault_q;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Instruction sequencer for the 8-bit core. Owns the program counter and drives it into the program memory. Latches the returned 16-bit instruction and walks each instruction through a fetch/decode/execute FSM. Resolves control-flow opcodes (JMP, JZ, HLT) itself, hands every other opcode to the ALU datapath with a one-cycle execute strobe, and supports free-run and single-step operation.

Parameters:
PC_WIDTH, 8, width of program counter and of jump target field
IR_WIDTH, 16, instruction width
CMD_CNT, 64, number of valid program memory words; legal PC range is 0..CMD_CNT-1

Ports:
clk  in  1  system clock, all state on rising edge
res  in  1  asynchronous, active-high reset
run  in  1  level; high = fetch continuously
step  in  1  one-cycle pulse; executes exactly one instruction while run low
ir_in  in  IR_WIDTH  instruction word from program memory, combinational on pc
zero_flag  in  1  datapath zero flag, sampled in DECODE for JZ
dp_busy  in  1  datapath multi-cycle busy; holds WAIT state
pc  out  PC_WIDTH  program counter to program memory
ir  out  IR_WIDTH  latched current instruction to datapath decode
exec_en  out  1  one-cycle strobe: datapath executes ir
halted  out  1  high in HALT state
fault  out  1  sticky; jump target out of range

Behaviour:
- Reset (res high, async): pc=0, ir=0, exec_en=0, halted=0, fault=0, state=IDLE. Asserting res mid-instruction aborts immediately, with no pc update.
- Opcode = ir[15:12]; target = ir[7:0] (zero-extended/truncated to PC_WIDTH).
- Control opcodes: 4'b0101 JMP, 4'b0110 JZ, 4'b1111 HLT. All other opcodes (0000 add, 0001 and, 0010 or/not, 0100 val, ...) are datapath ops.
- States: IDLE, FETCH, DECODE, EXEC, WAIT, HALT.
- IDLE: run=1 -> FETCH. Otherwise step=1 -> FETCH. Otherwise stay. step is sampled only in IDLE and ignored in all other states.
- FETCH: ir <= ir_in (value addressed by current pc). -> DECODE.
- DECODE, by opcode:
  - HLT: -> HALT; pc unchanged.
  - JMP: if target < CMD_CNT, pc <= target; else fault<=1, -> HALT.
  - JZ: if zero_flag=1, same as JMP; else pc <= next_pc.
  - JMP/JZ (no fault) next state: FETCH if run=1, else IDLE.
  - Datapath op: -> EXEC.
- EXEC: exec_en=1 for exactly this cycle. -> WAIT.
- WAIT: while dp_busy=1 stay. When dp_busy=0: pc <= next_pc; next state FETCH if run=1, else IDLE.
- HALT: halted=1. Exit only via res. run and step are ignored.
- next_pc = pc+1, or 0 when pc = CMD_CNT-1 (wrap).
- Timing with dp_busy low and run high: datapath op takes 4 cycles (FETCH, DECODE, EXEC, WAIT); jump/branch takes 2 cycles (FETCH, DECODE).
- run dropped mid-instruction: the current instruction completes, then the FSM parks in IDLE.
- run=1 and step=1 together in IDLE: treated as run.
- exec_en is never high outside EXEC. pc changes only at DECODE (control ops) or at WAIT exit.
- ir holds its value until the next FETCH.
- fault stays set until reset.

Test Plan:
- Reset, then run=1 with memory {0:4903, 1:4A14, 2:0910, 3:F000}, dp_busy=0 -> exec_en pulses in cycles 3, 7, 11; pc sequence 0->1->2->3; halted=1 after DECODE of word 3; pc stays 3.
- Memory {0:5005, 5:F000}, run=1 -> pc 0->5 two cycles after start, exec_en never asserted, halted=1.
- JZ at 0 (6008) with zero_flag=1 -> pc=8; repeat with zero_flag=0 -> pc=1.
- JMP with target 8'h50 and CMD_CNT=64 -> fault=1, halted=1, pc stays 0.
- run=0, single step pulse on word 4903 -> one exec_en pulse, pc=1, state IDLE. A second step pulse -> pc=2. A step pulse delivered while in WAIT is ignored.
- dp_busy held high 5 cycles after EXEC -> pc holds during those cycles and advances on the first cycle with dp_busy=0. res asserted in WAIT -> pc=0, ir=0, exec_en=0 immediately.
- pc=63 executing a datapath op -> pc wraps to 0.
